// File: rtl/option_sequencer.sv
// option_sequencer: circular option store replaying line headers and options to the solver, with per-line live counts.
// Beats are registered (one cycle pop-to-present), option_ready stalls replay, load_ready drops when full; STALL_DETECT_EN adds pass-stall detection.
module option_sequencer #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 1024,
  parameter int MAX_LINES = 22,
  parameter int CNT_W     = 7
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                load_valid,
  input  logic                                load_header,
  input  logic [WIDTH-1:0]                    load_data,
  output logic                                load_ready,
  input  logic                                started,
  output logic [WIDTH-1:0]                    option,
  output logic                                option_valid,
  output logic                                new_line,
  input  logic                                option_ready,
  input  logic                                resp_valid,
  input  logic                                put_back_to_FIFO,
  input  logic [WIDTH-1:0]                    new_option,
  input  logic                                solved,
  output logic [MAX_LINES-1:0][CNT_W-1:0]     old_options_amnt,
  output logic                                busy,
  output logic                                done
`ifdef STALL_DETECT_EN
  ,
  output logic                                stuck
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH:0]     mem [DEPTH];
  logic [PTR_W-1:0]   head, tail, head_n;
  logic [PTR_W:0]     occ, occ_n;
  logic [1:0]         state, state_n;
  logic [WIDTH-1:0]   cur_line, hdr_idx;
  logic [CNT_W-1:0]   cur_cnt;
  logic               cur_vld;
  logic               full, load_acc, hs, hs_hdr, hs_opt, keep, push, pop;
  logic               valid_n, new_hdr, commit, cnt_inc, stall_hit;
  logic [WIDTH:0]     push_entry, entry_n;

  assign full       = (occ == (PTR_W+1)'(DEPTH));
  assign load_ready = (state == S_IDLE) && !full;
  assign load_acc   = load_valid && load_ready;
  assign hs         = (state == S_ISSUE) && option_valid && option_ready;
  assign hs_hdr     = hs && new_line;
  assign hs_opt     = hs && !new_line;
  assign keep       = (state == S_WAIT) && resp_valid && put_back_to_FIFO;
  assign busy       = (state == S_ISSUE) || (state == S_WAIT);
  assign pop        = hs;

  // started wins over a coincident load for line tracking; the entry itself is still stored
  assign new_hdr = (load_acc && load_header && !started) || hs_hdr;
  assign hdr_idx = hs_hdr ? option : load_data;
  assign commit  = cur_vld && (new_hdr || ((state == S_IDLE) && started));
  assign cnt_inc = (load_acc && !load_header && !started) || keep;

  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (load_acc) begin
      push       = 1'b1;
      push_entry = {load_header, load_data};
    end else if (hs_hdr) begin
      push       = 1'b1;
      push_entry = {1'b1, option};
    end else if (keep) begin
      push       = 1'b1;
      push_entry = {1'b0, new_option};
    end
  end

  always_comb begin
    head_n  = pop ? head + PTR_W'(1) : head;
    occ_n   = occ + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    state_n = state;
    case (state)
      S_IDLE:  if (started) state_n = S_ISSUE;
      S_ISSUE: if (hs_opt) state_n = S_WAIT;
      S_WAIT:  if (resp_valid) state_n = S_ISSUE;
      default: state_n = S_DONE;
    endcase
    if (stall_hit || solved) state_n = S_DONE;
    valid_n = (state_n == S_ISSUE) && (occ_n != '0);
    // bypass the slot being written this cycle when it becomes the new head
    entry_n = (push && (tail == head_n)) ? push_entry : mem[head_n];
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      head             <= '0;
      tail             <= '0;
      occ              <= '0;
      option_valid     <= 1'b0;
      new_line         <= 1'b0;
      option           <= '0;
      done             <= 1'b0;
      cur_line         <= '0;
      cur_cnt          <= '0;
      cur_vld          <= 1'b0;
      old_options_amnt <= '0;
    end else begin
      state        <= state_n;
      head         <= head_n;
      tail         <= tail + PTR_W'(push);
      occ          <= occ_n;
      option_valid <= valid_n;
      {new_line, option} <= valid_n ? entry_n : '0;
      done         <= (state_n == S_DONE);
      if (commit) begin
        for (int i = 0; i < MAX_LINES; i++)
          if (cur_line == WIDTH'(i)) old_options_amnt[i] <= cur_cnt;
      end
      if ((state == S_IDLE) && started) begin
        cur_vld <= 1'b0;
      end else if (new_hdr) begin
        cur_line <= hdr_idx;
        cur_cnt  <= '0;
        cur_vld  <= 1'b1;
      end else if (cnt_inc && (cur_cnt != CNT_MAX)) begin
        cur_cnt <= cur_cnt + CNT_W'(1);
      end
    end
  end

`ifdef STALL_DETECT_EN
  logic             pass_seen, pass_dirty, pass_start, cnt_chg, drop, in_range;
  logic [CNT_W-1:0] old_cur;

  assign drop = (state == S_WAIT) && resp_valid && !put_back_to_FIFO;

  always_comb begin
    old_cur  = '0;
    in_range = 1'b0;
    for (int i = 0; i < MAX_LINES; i++) begin
      if (cur_line == WIDTH'(i)) begin
        old_cur  = old_options_amnt[i];
        in_range = 1'b1;
      end
    end
  end

  assign cnt_chg    = commit && in_range && (old_cur != cur_cnt);
  assign pass_start = hs_hdr && (option == '0);
  // the commit landing on the index-0 header closes the previous pass, so it counts toward it
  assign stall_hit  = pass_start && pass_seen && !pass_dirty && !cnt_chg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_seen  <= 1'b0;
      pass_dirty <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      if (pass_start) begin
        pass_seen  <= 1'b1;
        pass_dirty <= 1'b0;
      end else if (drop || cnt_chg) begin
        pass_dirty <= 1'b1;
      end
      if (stall_hit) stuck <= 1'b1;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

endmodule
